// File: rtl/pwm_pkg.sv
// pwm_pkg: shared mode encodings and default widths for the PWM timebase.
// Imported by pwm_timebase_if, pwm_prescaler and pwm_timebase.
// Mode 2'b11 has no constant; consumers treat it the same as MODE_UP.
package pwm_pkg;

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_UPDOWN = 2'b10;

  localparam int PWM_CNT_W = 16;
  localparam int PWM_PSC_W = 8;

endpackage

// File: rtl/pwm_timebase_if.sv
// pwm_timebase_if: configuration inputs and timebase outputs of pwm_timebase.
// master: register file / consumer side (drives en, count_reset, mode, period, prescale).
// slave:  the timebase (drives count_val, dir, tick, ovf, unf).
interface pwm_timebase_if
  import pwm_pkg::*;
#(
  parameter int CNT_W = PWM_CNT_W,
  parameter int PSC_W = PWM_PSC_W
);

  logic             en;
  logic             count_reset;
  logic [1:0]       mode;
  logic [CNT_W-1:0] period;
  logic [PSC_W-1:0] prescale;
  logic [CNT_W-1:0] count_val;
  logic             dir;
  logic             tick;
  logic             ovf;
  logic             unf;

  modport master (
    output en, count_reset, mode, period, prescale,
    input  count_val, dir, tick, ovf, unf
  );

  modport slave (
    input  en, count_reset, mode, period, prescale,
    output count_val, dir, tick, ovf, unf
  );

endinterface

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: linear prescaler, tick once every psc_act+1 enabled clocks.
// Ports: clk, rst_n (async, active-low), en, count_reset (sync clear), psc_act -> tick.
// tick is combinational from en and the registered prescale count.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int PSC_W = PWM_PSC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             count_reset,
  input  logic [PSC_W-1:0] psc_act,
  output logic             tick
);

  logic [PSC_W-1:0] psc_cnt;

  assign tick = en && (psc_cnt == psc_act);

  // If psc_act drops below psc_cnt the count runs on and wraps through zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_cnt <= '0;
    end else if (count_reset) begin
      psc_cnt <= '0;
    end else if (en) begin
      psc_cnt <= tick ? '0 : psc_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_timebase.sv
// pwm_timebase: PWM counter with up / down / center-aligned modes, boundary pulses.
// Ports: clk, rst_n (async, active-low), bus (pwm_timebase_if.slave).
// Optional PWM_TIMEBASE_SHADOW_EN: period/prescale shadowed, reloaded at boundaries.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CNT_W = PWM_CNT_W,
  parameter int PSC_W = PWM_PSC_W
) (
  input  logic           clk,
  input  logic           rst_n,
  pwm_timebase_if.slave  bus
);

  logic [CNT_W-1:0] per_act;
  logic [PSC_W-1:0] psc_act;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_nxt;
  logic             dir_q;
  logic             dir_nxt;
  logic             ovf_q;
  logic             unf_q;
  logic             ovf_nxt;
  logic             unf_nxt;
  logic             tick;
  logic             mode_ud;

  assign mode_ud = (bus.mode == MODE_UPDOWN);

  pwm_prescaler #(.PSC_W(PSC_W)) u_prescaler (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (bus.en),
    .count_reset (bus.count_reset),
    .psc_act     (psc_act),
    .tick        (tick)
  );

  // Next count / direction / events for a tick. Outside up-down the stored
  // direction is pinned to 1 so that entering up-down always starts upward.
  always_comb begin
    count_nxt = count_q;
    dir_nxt   = mode_ud ? dir_q : 1'b1;
    ovf_nxt   = 1'b0;
    unf_nxt   = 1'b0;
    if (tick) begin
      case (bus.mode)
        MODE_DOWN: begin
          if (count_q == '0) begin
            count_nxt = per_act;
            unf_nxt   = 1'b1;
          end else begin
            count_nxt = count_q - 1'b1;
          end
        end
        MODE_UPDOWN: begin
          if (per_act == '0) begin
            // Degenerate period: hold at 0, report the top boundary each tick.
            count_nxt = '0;
            dir_nxt   = 1'b1;
            ovf_nxt   = 1'b1;
          end else if (dir_q) begin
            if (count_q >= per_act) begin
              count_nxt = per_act - 1'b1;
              dir_nxt   = 1'b0;
              ovf_nxt   = 1'b1;
            end else begin
              count_nxt = count_q + 1'b1;
            end
          end else begin
            if (count_q == '0) begin
              count_nxt = CNT_W'(1);
              dir_nxt   = 1'b1;
              unf_nxt   = 1'b1;
            end else begin
              count_nxt = count_q - 1'b1;
            end
          end
        end
        default: begin
          // MODE_UP and the unused encoding 2'b11.
          if (count_q >= per_act) begin
            count_nxt = '0;
            ovf_nxt   = 1'b1;
          end else begin
            count_nxt = count_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      dir_q   <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (bus.count_reset) begin
      count_q <= '0;
      dir_q   <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_nxt;
      dir_q   <= dir_nxt;
      ovf_q   <= ovf_nxt;
      unf_q   <= unf_nxt;
    end
  end

`ifdef PWM_TIMEBASE_SHADOW_EN
  // Center-aligned reloads only at the bottom so both halves of a period
  // use the same top value.
  logic boundary_load;
  assign boundary_load = mode_ud ? unf_nxt : (ovf_nxt | unf_nxt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_act <= '0;
      psc_act <= '0;
    end else if (!bus.en || bus.count_reset || boundary_load) begin
      per_act <= bus.period;
      psc_act <= bus.prescale;
    end
  end
`else
  assign per_act = bus.period;
  assign psc_act = bus.prescale;
`endif

  assign bus.count_val = count_q;
  assign bus.dir       = mode_ud ? dir_q : 1'b1;
  assign bus.tick      = tick;
  assign bus.ovf       = ovf_q;
  assign bus.unf       = unf_q;

endmodule
